// File: rtl/odd_parity_scheduler_if.sv
// Request, shared-checker, response and error-counter signals of odd_parity_scheduler.
// The slave modport is the scheduler; the master modport is the requester/consumer side.
interface odd_parity_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 16,
   parameter int CNT_W   = 16
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic [DATA_W-1:0]         chk_data;
   logic                      chk_parity;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [ID_W-1:0]           rsp_id;
   logic [DATA_W-1:0]         rsp_data;
   logic                      rsp_ok;
   logic                      clr_count;
   logic [CNT_W-1:0]          err_count;

   modport master (
      output req_valid, req_data, chk_parity, rsp_ready, clr_count,
      input  req_ready, chk_data, rsp_valid, rsp_id, rsp_data, rsp_ok, err_count
   );

   modport slave (
      input  req_valid, req_data, chk_parity, rsp_ready, clr_count,
      output req_ready, chk_data, rsp_valid, rsp_id, rsp_data, rsp_ok, err_count
   );
endinterface

// File: rtl/odd_parity_scheduler.sv
// Round-robin scheduler sharing one external odd-parity checker among NUM_REQ requesters,
// returning each result over a valid/ready port and counting parity failures (saturating).
module odd_parity_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 16,
   parameter int CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   odd_parity_scheduler_if.slave bus
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CHECK = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

   logic [1:0]        state_q, state_d;
   logic [ID_W-1:0]   lastGrant_q, lastGrant_d;
   logic [ID_W-1:0]   holdId_q, holdId_d;
   logic [DATA_W-1:0] chkData_q, chkData_d;
   logic              rspValid_q, rspValid_d;
   logic [ID_W-1:0]   rspId_q, rspId_d;
   logic [DATA_W-1:0] rspData_q, rspData_d;
   logic              rspOk_q, rspOk_d;
   logic [CNT_W-1:0]  errCount_q, errCount_d;

   logic              grantFound;
   logic [ID_W-1:0]   grantId;
   logic [ID_W-1:0]   candId;
   logic [DATA_W-1:0] grantData;
   logic [NUM_REQ-1:0] reqReady;

   // Search upward from the requester after the last grant, wrapping modulo NUM_REQ.
   always_comb begin
      grantFound = 1'b0;
      grantId    = '0;
      candId     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         candId = ID_W'((int'(lastGrant_q) + k) % NUM_REQ);
         if (!grantFound && bus.req_valid[candId]) begin
            grantFound = 1'b1;
            grantId    = candId;
         end
      end
   end

   assign grantData = bus.req_data[int'(grantId)*DATA_W +: DATA_W];

   always_comb begin
      reqReady = '0;
      if (state_q == IDLE && grantFound) begin
         reqReady[grantId] = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      lastGrant_d = lastGrant_q;
      holdId_d    = holdId_q;
      chkData_d   = chkData_q;
      rspValid_d  = rspValid_q;
      rspId_d     = rspId_q;
      rspData_d   = rspData_q;
      rspOk_d     = rspOk_q;
      errCount_d  = errCount_q;

      case (state_q)
         IDLE: begin
            if (grantFound) begin
               chkData_d   = grantData;
               holdId_d    = grantId;
               lastGrant_d = grantId;
               state_d     = CHECK;
            end
         end
         CHECK: begin
            rspOk_d    = bus.chk_parity;
            rspData_d  = chkData_q;
            rspId_d    = holdId_q;
            rspValid_d = 1'b1;
            state_d    = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rspValid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A clear on the same edge as an increment wins and drops that error.
      if (bus.clr_count) begin
         errCount_d = '0;
      end else if (state_q == CHECK && !bus.chk_parity && errCount_q != CNT_MAX) begin
         errCount_d = errCount_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         lastGrant_q <= LAST_ID;
         holdId_q    <= '0;
         chkData_q   <= '0;
         rspValid_q  <= 1'b0;
         rspId_q     <= '0;
         rspData_q   <= '0;
         rspOk_q     <= 1'b0;
         errCount_q  <= '0;
      end else begin
         state_q     <= state_d;
         lastGrant_q <= lastGrant_d;
         holdId_q    <= holdId_d;
         chkData_q   <= chkData_d;
         rspValid_q  <= rspValid_d;
         rspId_q     <= rspId_d;
         rspData_q   <= rspData_d;
         rspOk_q     <= rspOk_d;
         errCount_q  <= errCount_d;
      end
   end

   assign bus.req_ready = reqReady;
   assign bus.chk_data  = chkData_q;
   assign bus.rsp_valid = rspValid_q;
   assign bus.rsp_id    = rspId_q;
   assign bus.rsp_data  = rspData_q;
   assign bus.rsp_ok    = rspOk_q;
   assign bus.err_count = errCount_q;
endmodule

// File: tb/tb_odd_parity_scheduler.sv
// Bench for odd_parity_scheduler: table vectors plus multi-cycle sequences, responses scored
// against a queue of expectations; a second instance with a 4-bit counter covers saturation.
module tb_odd_parity_scheduler;
   logic clk = 1'b0;
   logic rstN;
   always #5 clk = ~clk;

   odd_parity_scheduler_if #(.NUM_REQ(4), .DATA_W(16), .CNT_W(16)) mainBus ();
   odd_parity_scheduler_if #(.NUM_REQ(4), .DATA_W(16), .CNT_W(4))  satBus ();

   odd_parity_scheduler #(.NUM_REQ(4), .DATA_W(16), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rstN), .bus(mainBus)
   );
   odd_parity_scheduler #(.NUM_REQ(4), .DATA_W(16), .CNT_W(4)) satDut (
      .clk(clk), .rst_n(rstN), .bus(satBus)
   );

   assign mainBus.chk_parity = ^mainBus.chk_data;
   assign satBus.chk_parity  = ^satBus.chk_data;

   typedef struct { int id; logic [15:0] data; logic ok; } expT;
   typedef struct { logic [3:0] mask; logic [63:0] words; int grant; logic ok; } vecT;

   expT sbQueue[$];
   vecT vecs[8];
   int  errors = 0;
   int  checks = 0;
   int  cyc = 0;
   int  expErr = 0;
   int  lastGrantCyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic failNow(input string name, input string what);
      checks++;
      errors++;
      $display("[TB] FAIL %s: %s (cycle %0d)", name, what, cyc);
   endtask

   task automatic applyStimulus(input logic [3:0] mask, input logic [63:0] words);
      mainBus.req_valid = mask;
      mainBus.req_data  = words;
   endtask

   // Waits for a grant, checks it and the CHECK cycle, returns just after entering RESP.
   task automatic acceptOne(input int expGrant, input logic [15:0] expData, input logic expOk);
      bit seen;
      expT e;
      seen = 1'b0;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         if (mainBus.req_ready != 4'b0) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         failNow("grantTimeout", "no req_ready within 30 cycles, required a grant");
         return;
      end
      lastGrantCyc = cyc;
      checkOutput("reqReady", 64'(mainBus.req_ready), 64'(4'b0001 << expGrant));
      e.id = expGrant;
      e.data = expData;
      e.ok = expOk;
      sbQueue.push_back(e);
      if (!expOk) expErr++;
      @(negedge clk);
      checkOutput("rspValidInCheck", 64'(mainBus.rsp_valid), 64'(0));
      checkOutput("readyInCheck", 64'(mainBus.req_ready), 64'(0));
      checkOutput("chkData", 64'(mainBus.chk_data), 64'(expData));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int t = 0; t < 30 && sbQueue.size() != 0; t++) @(negedge clk);
      if (sbQueue.size() != 0) begin
         failNow("drainTimeout", $sformatf("%0d responses outstanding, required 0", sbQueue.size()));
         sbQueue.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rstN = 1'b0;
      applyStimulus(4'b0, 64'h0);
      sbQueue.delete();
      expErr = 0;
      repeat (2) @(posedge clk);
      #1;
      rstN = 1'b1;
   endtask

   always @(negedge clk) begin
      expT e;
      if (rstN && mainBus.rsp_valid && mainBus.rsp_ready) begin
         if (sbQueue.size() == 0) begin
            failNow("unexpectedRsp", $sformatf("response id %0d data 0x%0h, required none",
                    mainBus.rsp_id, mainBus.rsp_data));
         end else begin
            e = sbQueue.pop_front();
            checkOutput("rspId", 64'(mainBus.rsp_id), 64'(e.id));
            checkOutput("rspData", 64'(mainBus.rsp_data), 64'(e.data));
            checkOutput("rspOk", 64'(mainBus.rsp_ok), 64'(e.ok));
            checkOutput("errCount", 64'(mainBus.err_count), 64'(expErr));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [63:0] w;
      logic [15:0] word;
      int prevCyc;
      int raiseCyc;
      bit seen;

      vecs[0] = '{4'b0001, 64'h0000_0000_0000_0001, 0, 1'b1};
      vecs[1] = '{4'b0001, 64'h0000_0000_0000_0003, 0, 1'b0};
      vecs[2] = '{4'b0110, 64'h0000_0007_00FF_0000, 1, 1'b0};
      vecs[3] = '{4'b0110, 64'h0000_0007_00FF_0000, 2, 1'b1};
      vecs[4] = '{4'b1001, 64'h8000_0000_0000_FFFF, 3, 1'b1};
      vecs[5] = '{4'b1001, 64'h8000_0000_0000_FFFF, 0, 1'b0};
      vecs[6] = '{4'b1000, 64'h1234_0000_0000_0000, 3, 1'b1};
      vecs[7] = '{4'b1111, 64'h3333_2222_1111_AAAA, 0, 1'b0};

      rstN = 1'b0;
      applyStimulus(4'b0, 64'h0);
      mainBus.rsp_ready = 1'b1;
      mainBus.clr_count = 1'b0;
      satBus.req_valid  = 4'b0;
      satBus.req_data   = 64'h0;
      satBus.rsp_ready  = 1'b1;
      satBus.clr_count  = 1'b0;

      @(negedge clk);
      checkOutput("resetReqReady", 64'(mainBus.req_ready), 64'(0));
      checkOutput("resetRspValid", 64'(mainBus.rsp_valid), 64'(0));
      checkOutput("resetRspId", 64'(mainBus.rsp_id), 64'(0));
      checkOutput("resetRspData", 64'(mainBus.rsp_data), 64'(0));
      checkOutput("resetRspOk", 64'(mainBus.rsp_ok), 64'(0));
      checkOutput("resetChkData", 64'(mainBus.chk_data), 64'(0));
      checkOutput("resetErrCount", 64'(mainBus.err_count), 64'(0));
      @(posedge clk);
      #1;
      rstN = 1'b1;

      for (int i = 0; i < 8; i++) begin
         w = vecs[i].words;
         applyStimulus(vecs[i].mask, w);
         acceptOne(vecs[i].grant, w[vecs[i].grant*16 +: 16], vecs[i].ok);
         applyStimulus(4'b0, w);
         drain();
      end

      // Round-robin with all requesters held high: fresh reset, so order starts at 0.
      doReset();
      w = 64'h0F0F_0700_00FF_0001;
      applyStimulus(4'b1111, w);
      prevCyc = 0;
      for (int k = 0; k < 6; k++) begin
         acceptOne(k % 4, w[(k % 4)*16 +: 16], ((4'b0101 >> (k % 4)) & 4'b1) != 4'b0);
         if (k > 0) checkOutput("grantSpacing", 64'(lastGrantCyc - prevCyc), 64'(3));
         prevCyc = lastGrantCyc;
      end
      applyStimulus(4'b0, w);
      drain();

      // Backpressure: response held for 10 cycles, then the next grant follows the handshake.
      mainBus.rsp_ready = 1'b0;
      applyStimulus(4'b0100, 64'h0000_5A5A_0000_0000);
      acceptOne(2, 16'h5A5A, 1'b0);
      applyStimulus(4'b0001, 64'h0000_5A5A_0000_0007);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("stallValid", 64'(mainBus.rsp_valid), 64'(1));
         checkOutput("stallId", 64'(mainBus.rsp_id), 64'(2));
         checkOutput("stallData", 64'(mainBus.rsp_data), 64'h5A5A);
         checkOutput("stallOk", 64'(mainBus.rsp_ok), 64'(0));
         checkOutput("stallReady", 64'(mainBus.req_ready), 64'(0));
      end
      @(posedge clk);
      #1;
      mainBus.rsp_ready = 1'b1;
      raiseCyc = cyc;
      acceptOne(0, 16'h0007, 1'b1);
      checkOutput("grantAfterStall", 64'(lastGrantCyc), 64'(raiseCyc + 1));
      applyStimulus(4'b0, 64'h0);
      drain();

      // Reset while in CHECK: nothing comes out, counter clears, grant restarts at 0.
      applyStimulus(4'b0011, 64'h0000_0000_0003_0001);
      seen = 1'b0;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         if (mainBus.req_ready != 4'b0) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) failNow("midResetGrant", "no grant within 30 cycles, required requester 1");
      else checkOutput("midResetGrant", 64'(mainBus.req_ready), 64'(4'b0010));
      @(posedge clk);
      #1;
      rstN = 1'b0;
      #1;
      checkOutput("midResetRspValid", 64'(mainBus.rsp_valid), 64'(0));
      checkOutput("midResetErrCount", 64'(mainBus.err_count), 64'(0));
      checkOutput("midResetChkData", 64'(mainBus.chk_data), 64'(0));
      sbQueue.delete();
      expErr = 0;
      @(posedge clk);
      #1;
      rstN = 1'b1;
      acceptOne(0, 16'h0001, 1'b1);
      applyStimulus(4'b0, 64'h0);
      drain();
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1;

      // Sweep through requester 2: 4096 consecutive words, half with even parity.
      for (int i = 0; i < 4096; i++) begin
         word = 16'(i);
         applyStimulus(4'b0100, {16'h0, word, 32'h0});
         acceptOne(2, word, ^word);
      end
      applyStimulus(4'b0, 64'h0);
      drain();
      checkOutput("sweepErrCount", 64'(mainBus.err_count), 64'(2048));
      for (int i = 0; i < 32; i++) begin
         word = 16'($urandom);
         applyStimulus(4'b0100, {16'h0, word, 32'h0});
         acceptOne(2, word, ^word);
      end
      applyStimulus(4'b0, 64'h0);
      drain();
      checkOutput("randomErrCount", 64'(mainBus.err_count), 64'(expErr));

      // Saturation on the 4-bit counter, then clear priority over a same-edge increment.
      satBus.req_data  = 64'h0000_0000_0000_FFFF;
      satBus.req_valid = 4'b0001;
      for (int n = 0; n < 17; n++) begin
         seen = 1'b0;
         for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (satBus.req_ready[0]) begin
               seen = 1'b1;
               break;
            end
         end
         if (!seen) failNow("satGrant", "no grant on saturation instance within 30 cycles");
         if (n == 15) checkOutput("satAt15", 64'(satBus.err_count), 64'(15));
         @(posedge clk);
         #1;
      end
      satBus.req_valid = 4'b0;
      repeat (4) @(negedge clk);
      checkOutput("satFinal", 64'(satBus.err_count), 64'(15));

      @(posedge clk);
      #1;
      satBus.clr_count = 1'b1;
      @(posedge clk);
      #1;
      satBus.clr_count = 1'b0;
      @(negedge clk);
      checkOutput("satIdleClear", 64'(satBus.err_count), 64'(0));

      @(posedge clk);
      #1;
      satBus.req_valid = 4'b0001;
      seen = 1'b0;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         if (satBus.req_ready[0]) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) failNow("clrGrant", "no grant on saturation instance within 30 cycles");
      @(posedge clk);
      #1;
      satBus.req_valid = 4'b0;
      satBus.clr_count = 1'b1;
      @(posedge clk);
      #1;
      satBus.clr_count = 1'b0;
      @(negedge clk);
      checkOutput("clrBeatsIncrement", 64'(satBus.err_count), 64'(0));
      checkOutput("clrRspValid", 64'(satBus.rsp_valid), 64'(1));
      checkOutput("clrRspOk", 64'(satBus.rsp_ok), 64'(0));

      @(posedge clk);
      #1;
      satBus.req_valid = 4'b0001;
      seen = 1'b0;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         if (satBus.req_ready[0]) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) failNow("afterClrGrant", "no grant on saturation instance within 30 cycles");
      @(posedge clk);
      #1;
      satBus.req_valid = 4'b0;
      repeat (3) @(negedge clk);
      checkOutput("countAfterClear", 64'(satBus.err_count), 64'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
